// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - access size encodings (SIZE_WORD / SIZE_HALF / SIZE_BYTE / SIZE_RSVD)
//   - FSM state enum (IDLE, RMW_RD, RMW_WR)
//   - big-endian lane-select constants
//   - helpers classifying sub-word and misaligned accesses
// -----------------------------------------------------------------------------
package dmem_pkg;

  // Access size encodings on data_size. The reserved code behaves as a word.
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } dmem_state_e;

  // Big-endian lanes: byte lane 0 is bits 31:24, half lane 0 is bits 31:16.
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       LANE_H0 = 1'b0;
  localparam logic       LANE_H1 = 1'b1;

  // Half and byte accesses need a read-modify-write to store.
  function automatic logic is_subword(input logic [1:0] size);
    return (size == SIZE_HALF) || (size == SIZE_BYTE);
  endfunction

  // Half on an odd address, or word (incl. reserved) not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = lo[0];
      SIZE_BYTE: mis = 1'b0;
      default:   mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store port between the MEM stage (master) and the data-memory
// responder (slave).
//   req_valid  : request present this cycle
//   addr       : byte address
//   wr_data    : store data, right-justified for sub-word sizes
//   mem_wr     : 1 = store, 0 = load
//   data_size  : 00 word, 01 half, 10 byte, 11 reserved (word)
//   rd_data    : unshifted word read from the array
//   rd_valid   : one-cycle pulse, rd_data holds a load result
//   stall      : master must hold its request while high
//   misalign   : one-cycle misaligned-access flag
//   dbg_state  : responder FSM state, observation only
//
// Handshake: a request is taken on a rising edge where req_valid=1 and the
// responder is IDLE. If stall is high in that cycle the master holds the
// request; the responder has already latched it and ignores the inputs until
// it returns to IDLE. A load's rd_valid pulses exactly one cycle after it is
// taken; there is no back-pressure on the response.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        mem_wr;
  logic [1:0]  data_size;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        misalign;
  dmem_state_e dbg_state;

  modport master (
    output req_valid, addr, wr_data, mem_wr, data_size,
    input  rd_data, rd_valid, stall, misalign, dbg_state
  );

  modport slave (
    input  req_valid, addr, wr_data, mem_wr, data_size,
    output rd_data, rd_valid, stall, misalign, dbg_state
  );
endinterface

// File: rtl/dmem_lane_merge.sv
// -----------------------------------------------------------------------------
// dmem_lane_merge
// Combinational merge of right-justified store data into an existing word,
// big-endian lane order.
//   old_word : word currently in the array
//   wr_data  : store data, right-justified
//   size     : access size encoding
//   lane     : addr[1:0] of the store
//   new_word : old_word with the selected lane replaced (whole word for
//              word / reserved sizes)
// -----------------------------------------------------------------------------
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    case (size)
      SIZE_BYTE: begin
        case (lane)
          LANE_B0: new_word[31:24] = wr_data[7:0];
          LANE_B1: new_word[23:16] = wr_data[7:0];
          LANE_B2: new_word[15:8]  = wr_data[7:0];
          default: new_word[7:0]   = wr_data[7:0];
        endcase
      end
      SIZE_HALF: begin
        // lane[0] does not pick a half lane; an odd half is treated by addr[1].
        if (lane[1] == LANE_H0) new_word[31:16] = wr_data[15:0];
        else                    new_word[15:0]  = wr_data[15:0];
      end
      default: new_word = wr_data;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Target-side data memory for the pipeline's load/store port. Single-ported
// word-wide array without byte enables; half/byte stores run as a 3-cycle
// read-modify-write with stall held high. Loads return the raw word one
// cycle after acceptance.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset (array contents are kept)
//   bus   : dmem_responder_if.slave (request, response, stall, misalign,
//           dbg_state)
//
// Parameters:
//   DEPTH : number of 32-bit words
//   AW    : word-index width, must equal $clog2(DEPTH)
//
// Optional feature macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// half/word accesses raise misalign for one cycle and stores among them are
// dropped; loads still return the aligned word. When undefined, misalign
// stays 0 and low address bits only select the lane.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic              clk,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  logic [31:0] mem [DEPTH];

  dmem_state_e state, state_nxt;

  logic [AW-1:0] idx;
  logic          mis;
  logic          accept;
  logic          do_load;
  logic          do_wstore;
  logic          do_sub;
  logic          stall_c;

  // Latched sub-word store and the word read back during RMW_RD.
  logic [AW-1:0] lat_idx;
  logic [1:0]    lat_lane;
  logic [1:0]    lat_size;
  logic [31:0]   lat_data;
  logic [31:0]   hold_word;
  logic [31:0]   merged_word;

  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic          misalign_q;

  assign idx = bus.addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = is_misaligned(bus.data_size, bus.addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Requests are only looked at in IDLE; otherwise the held inputs are stale.
  assign accept    = (state == IDLE) && bus.req_valid;
  assign do_load   = accept && !bus.mem_wr;
  assign do_wstore = accept &&  bus.mem_wr && !is_subword(bus.data_size) && !mis;
  assign do_sub    = accept &&  bus.mem_wr &&  is_subword(bus.data_size) && !mis;

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      IDLE: begin
        if (do_sub) begin
          stall_c   = 1'b1;
          state_nxt = RMW_RD;
        end
      end
      RMW_RD: begin
        stall_c   = 1'b1;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        stall_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      lat_idx    <= '0;
      lat_lane   <= '0;
      lat_size   <= '0;
      lat_data   <= '0;
      hold_word  <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid_q <= do_load;
      misalign_q <= accept && mis;
      if (do_load) rd_data_q <= mem[idx];
      if (do_sub) begin
        lat_idx  <= idx;
        lat_lane <= bus.addr[1:0];
        lat_size <= bus.data_size;
        lat_data <= bus.wr_data;
      end
      if (state == RMW_RD) hold_word <= mem[lat_idx];
    end
  end

  dmem_lane_merge u_merge (
    .old_word (hold_word),
    .wr_data  (lat_data),
    .size     (lat_size),
    .lane     (lat_lane),
    .new_word (merged_word)
  );

  // Array is not reset. Reset also blocks writes so an RMW caught by reset
  // leaves the stored word untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_wstore)             mem[idx]     <= bus.wr_data;
      else if (state == RMW_WR)  mem[lat_idx] <= merged_word;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.stall     = stall_c;
  assign bus.misalign  = misalign_q;
  assign bus.dbg_state = state;

  // Address bits above the index are ignored (accesses wrap modulo DEPTH).
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:AW+2];

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Inputs change on the falling edge;
// outputs are sampled 1 ns later, so registered outputs show the result of
// the previous rising edge and stall shows the current request.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] exp_q[$];

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(1024), .AW(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid = v;
    bus.mem_wr    = wr;
    bus.data_size = sz;
    bus.addr      = a;
    bus.wr_data   = d;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
  endtask

  task automatic issue_load(input logic [31:0] a, input logic [1:0] sz,
                            input logic [31:0] expected);
    drive(1'b1, 1'b0, sz, a, 32'h0);
    exp_q.push_back(expected);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.mem_wr = 1'b0; bus.data_size = SIZE_WORD;
    bus.addr = '0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.rd_data !== 32'h0 || bus.rd_valid !== 1'b0 || bus.stall !== 1'b0 ||
        bus.misalign !== 1'b0 || bus.dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_init got rd_data=%h rd_valid=%b stall=%b misalign=%b state=%0d exp 0/0/0/0/IDLE",
               bus.rd_data, bus.rd_valid, bus.stall, bus.misalign, bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_word_store_load();
    logic [31:0] e;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h10, 32'hDEADBEEF);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL word_store_stall got=%b exp=0", bus.stall);
    end
    issue_load(32'h10, SIZE_WORD, 32'hDEADBEEF);
    total++;
    if (bus.rd_valid !== 1'b0 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL word_store_no_rdvalid got rd_valid=%b stall=%b exp 0/0", bus.rd_valid, bus.stall);
    end
    idle_cycle();
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL word_load got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
    idle_cycle();
    total++;
    if (bus.rd_valid !== 1'b0) begin
      bad++; $display("FAIL word_load_pulse got rd_valid=%b exp=0", bus.rd_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    issue_load(32'h10, SIZE_WORD, 32'hDEADBEEF);
    void'(exp_q.pop_front());
    idle_cycle();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL pre_reset_load got rd_valid=%b rd_data=%h exp 1/deadbeef", bus.rd_valid, bus.rd_data);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.rd_data !== 32'h0 || bus.rd_valid !== 1'b0 || bus.stall !== 1'b0 || bus.misalign !== 1'b0) begin
      bad++;
      $display("FAIL reset_async got rd_data=%h rd_valid=%b stall=%b misalign=%b exp 0/0/0/0",
               bus.rd_data, bus.rd_valid, bus.stall, bus.misalign);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_byte_store();
    int cnt;
    logic [31:0] e;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h20, 32'h11223344);
    drive(1'b1, 1'b1, SIZE_BYTE, 32'h22, 32'h000000AA);
    cnt = (bus.stall === 1'b1) ? 1 : 0;
    idle_cycle();
    total++;
    if (bus.dbg_state !== RMW_RD) begin
      bad++; $display("FAIL byte_state_rd got=%0d exp=%0d", bus.dbg_state, RMW_RD);
    end
    if (bus.stall === 1'b1) cnt++;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      if (bus.stall === 1'b1) cnt++;
    end
    total++;
    if (cnt != 3) begin
      bad++; $display("FAIL byte_stall_cycles got=%0d exp=3", cnt);
    end
    issue_load(32'h20, SIZE_WORD, 32'h1122AA44);
    idle_cycle();
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL byte_merge got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
  endtask

  task automatic test_half_store();
    int cnt;
    logic [31:0] e;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h20, 32'h11223344);
    drive(1'b1, 1'b1, SIZE_HALF, 32'h20, 32'h0000BEEF);
    cnt = (bus.stall === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      if (bus.stall === 1'b1) cnt++;
    end
    total++;
    if (cnt != 3) begin
      bad++; $display("FAIL half_stall_cycles got=%0d exp=3", cnt);
    end
    issue_load(32'h20, SIZE_WORD, 32'hBEEF3344);
    idle_cycle();
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL half_merge got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
  endtask

  task automatic test_rmw_reset();
    logic [31:0] e;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h30, 32'hCAFEF00D);
    drive(1'b1, 1'b1, SIZE_BYTE, 32'h31, 32'h00000055);
    idle_cycle();
    total++;
    if (bus.dbg_state !== RMW_RD) begin
      bad++; $display("FAIL rmw_reset_pre_state got=%0d exp=%0d", bus.dbg_state, RMW_RD);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b0 || bus.dbg_state !== IDLE) begin
      bad++; $display("FAIL rmw_reset_abort got stall=%b state=%0d exp 0/IDLE", bus.stall, bus.dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue_load(32'h30, SIZE_WORD, 32'hCAFEF00D);
    idle_cycle();
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL rmw_reset_data got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    drive(1'b1, 1'b1, SIZE_WORD, 32'h50, 32'h01020304);
    drive(1'b1, 1'b1, SIZE_BYTE, 32'h53, 32'h000000FF);
    idle_cycle();               // RMW_RD
    idle_cycle();               // RMW_WR
    issue_load(32'h50, SIZE_WORD, 32'h010203FF);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL b2b_load_stall got=%b exp=0", bus.stall);
    end
    drive(1'b1, 1'b1, SIZE_HALF, 32'h52, 32'h00007788);
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL b2b_raw_byte got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
    idle_cycle();
    idle_cycle();
    drive(1'b1, 1'b1, SIZE_RSVD, 32'h54, 32'h0BADF00D);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL rsvd_store_stall got=%b exp=0", bus.stall);
    end
    issue_load(32'h50, SIZE_WORD, 32'h01027788);
    issue_load(32'h54, SIZE_WORD, 32'h0BADF00D);
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL b2b_raw_half got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
    idle_cycle();
    e = exp_q.pop_front();
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL rsvd_word got rd_valid=%b rd_data=%h exp 1/%h", bus.rd_valid, bus.rd_data, e);
    end
  endtask

  task automatic test_idle_no_req();
    int hits;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      if (bus.rd_valid !== 1'b0 || bus.stall !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++; $display("FAIL idle_no_req got active_cycles=%0d exp=0", hits);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    logic        exp_mis;
`ifdef DMEM_MISALIGN_TRAP_EN
    exp_mis = 1'b1;
    e       = 32'hA5A5A5A5;   // misaligned store is dropped
`else
    exp_mis = 1'b0;
    e       = 32'h12345678;   // low bits ignored, store lands on 0x40
`endif
    drive(1'b1, 1'b1, SIZE_WORD, 32'h40, 32'hA5A5A5A5);
    drive(1'b1, 1'b1, SIZE_WORD, 32'h42, 32'h12345678);
    total++;
    if (bus.stall !== 1'b0) begin
      bad++; $display("FAIL mis_store_stall got=%b exp=0", bus.stall);
    end
    issue_load(32'h40, SIZE_WORD, e);
    total++;
    if (bus.misalign !== exp_mis) begin
      bad++; $display("FAIL mis_store_flag got=%b exp=%b", bus.misalign, exp_mis);
    end
    issue_load(32'h43, SIZE_HALF, e);
    e = exp_q.pop_front();
    total++;
    if (bus.misalign !== 1'b0 || bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL mis_word_after got misalign=%b rd_valid=%b rd_data=%h exp 0/1/%h",
                      bus.misalign, bus.rd_valid, bus.rd_data, e);
    end
    idle_cycle();
    e = exp_q.pop_front();
    total++;
    if (bus.misalign !== exp_mis || bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
      bad++; $display("FAIL mis_half_load got misalign=%b rd_valid=%b rd_data=%h exp %b/1/%h",
                      bus.misalign, bus.rd_valid, bus.rd_data, exp_mis, e);
    end
    idle_cycle();
    total++;
    if (bus.misalign !== 1'b0) begin
      bad++; $display("FAIL mis_pulse_end got=%b exp=0", bus.misalign);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_word_store_load();
    test_reset_mid_run();
    test_byte_store();
    test_half_store();
    test_rmw_reset();
    test_back_to_back();
    test_idle_no_req();
    test_misalign();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL exp_q_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
